// File: rtl/lea_round_ctrl.sv
// lea_round_ctrl
// Round sequencer for the LEA block-cipher datapath. A start request latches
// the round count for the selected key size, pulses load_en for one cycle,
// issues one rnd_en per cycle with its round index, then holds out_valid
// until the consumer accepts the block.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; key_len=11 raises err
// LOAD   | load_en pulse, plaintext and key enter the datapath
// ROUND  | rnd_en every cycle, rnd_idx 0..N-1, last_rnd on N-1
// DONE   | out_valid held until out_ready_i
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset, overrides every input
//   start_i      begin one block operation (sampled in IDLE only)
//   key_len_i    00=128, 01=192, 10=256, 11=reserved (sampled with start)
//   abort_i      synchronous cancel back to IDLE
//   out_ready_i  consumer accepts the finished block (used in DONE only)
//   busy_o       high in every state except IDLE
//   load_en_o    one-cycle datapath load pulse
//   rnd_en_o     advance datapath by one round
//   rnd_idx_o    index of the round being executed
//   last_rnd_o   high with rnd_en_o on round N-1
//   out_valid_o  result valid, held until accepted
//   err_o        one-cycle pulse for a start with key_len=11; registered,
//                so it appears in the cycle after the start cycle
//
// Every output is a flop; there is no combinational input-to-output path.

module lea_round_ctrl #(
    parameter int RND_W = 5,
    parameter int NR128 = 24,
    parameter int NR192 = 28,
    parameter int NR256 = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       key_len_i,
    input  logic             abort_i,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             load_en_o,
    output logic             rnd_en_o,
    output logic [RND_W-1:0] rnd_idx_o,
    output logic             last_rnd_o,
    output logic             out_valid_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [RND_W-1:0] idx_q, idx_d;
    // Latched as N-1 so the terminal compare needs no subtractor and the
    // 32-round case still fits in RND_W bits.
    logic [RND_W-1:0] lastidx_q, lastidx_d;
    logic             err_d;

    logic busy_q, load_en_q, rnd_en_q, last_rnd_q, out_valid_q, err_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lastidx_d = lastidx_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // abort in IDLE suppresses a simultaneous start (and its err)
                if (start_i && !abort_i) begin
                    case (key_len_i)
                        2'b00: begin
                            lastidx_d = RND_W'(NR128 - 1);
                            state_d   = S_LOAD;
                        end
                        2'b01: begin
                            lastidx_d = RND_W'(NR192 - 1);
                            state_d   = S_LOAD;
                        end
                        2'b10: begin
                            lastidx_d = RND_W'(NR256 - 1);
                            state_d   = S_LOAD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                idx_d   = '0;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (idx_q == lastidx_q) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + RND_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            idx_d   = '0;
        end
    end

    // Outputs are registered from the next-state values so each one lines up
    // with the state it describes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lastidx_q   <= RND_W'(NR128 - 1);
            busy_q      <= 1'b0;
            load_en_q   <= 1'b0;
            rnd_en_q    <= 1'b0;
            last_rnd_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lastidx_q   <= lastidx_d;
            busy_q      <= (state_d != S_IDLE);
            load_en_q   <= (state_d == S_LOAD);
            rnd_en_q    <= (state_d == S_ROUND);
            last_rnd_q  <= (state_d == S_ROUND) && (idx_d == lastidx_d);
            out_valid_q <= (state_d == S_DONE);
            err_q       <= err_d;
        end
    end

    assign busy_o      = busy_q;
    assign load_en_o   = load_en_q;
    assign rnd_en_o    = rnd_en_q;
    assign rnd_idx_o   = idx_q;
    assign last_rnd_o  = last_rnd_q;
    assign out_valid_o = out_valid_q;
    assign err_o       = err_q;

endmodule
